// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - RV32I load/store unit driving a word-wide memory without byte enables
// Optional alignment fault checking is enabled with `define LSU_ALIGN_CHECK_EN.
module lsu_mem_ctrl #(
  parameter int MEM_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_fault,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_load,
  output logic        o_mem_store,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW+1:0] r_addr;
  logic [2:0]    r_funct3;
  logic [31:0]   r_wdata;
  logic [31:0]   r_word;
  logic [31:0]   r_resp_rdata;
  logic          r_resp_fault;

  logic          w_accept;
  logic          w_illegal;
  logic          w_misalign;
  logic          w_fault;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;
  logic [31:0]   w_merged;
  logic          w_unused_addr;

  assign w_unused_addr = ^i_req_addr[31:AW+2];

  assign w_accept = i_req_valid && (r_state == S_IDLE);

  always_comb begin
    w_illegal = 1'b0;
    if (i_req_we) begin
      w_illegal = i_req_funct3[2] || (i_req_funct3 == 3'b011);
    end else begin
      w_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                  (i_req_funct3 == 3'b111);
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign w_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                      ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
  // Without the check, sub-lane address bits are simply ignored.
  assign w_misalign = 1'b0;
`endif

  assign w_fault = w_illegal || w_misalign;

  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  end

  always_comb begin
    w_load_data = 32'h0;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = i_mem_rdata;
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = 32'h0;
    endcase
  end

  // Sub-word store: splice the new lane into the word captured during RMW_RD.
  always_comb begin
    w_merged = r_word;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr[1:0])
        2'd0:    w_merged[7:0]   = r_wdata[7:0];
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_mem_load   = 1'b0;
    o_mem_store  = 1'b0;
    o_mem_wdata  = 32'h0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (w_accept) begin
          if (w_fault) begin
            w_next = S_RESP;
          end else if (!i_req_we) begin
            w_next = S_RD;
          end else if (i_req_funct3[1:0] == 2'b10) begin
            w_next = S_WR;
          end else begin
            w_next = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        o_mem_load = 1'b1;
        w_next     = S_RESP;
      end
      S_WR: begin
        o_mem_store = 1'b1;
        o_mem_wdata = r_wdata;
        w_next      = S_RESP;
      end
      S_RMW_RD: begin
        o_mem_load = 1'b1;
        w_next     = S_RMW_WR;
      end
      S_RMW_WR: begin
        o_mem_store = 1'b1;
        o_mem_wdata = w_merged;
        w_next      = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_addr       <= '0;
      r_funct3     <= 3'b000;
      r_wdata      <= 32'h0;
      r_word       <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= i_req_addr[AW+1:0];
        r_funct3 <= i_req_funct3;
        r_wdata  <= i_req_wdata;
        if (w_fault) begin
          r_resp_rdata <= 32'h0;
          r_resp_fault <= 1'b1;
        end
      end
      case (r_state)
        S_RD: begin
          r_resp_rdata <= w_load_data;
          r_resp_fault <= 1'b0;
        end
        S_RMW_RD: r_word <= i_mem_rdata;
        S_WR, S_RMW_WR: begin
          r_resp_rdata <= 32'h0;
          r_resp_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr   = {{(32-AW){1'b0}}, r_addr[AW+1:2]};
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_fault = r_resp_fault;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with a behavioural word memory
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_WORDS(64)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_fault (resp_fault),
    .o_mem_addr   (mem_addr),
    .o_mem_load   (mem_load),
    .o_mem_store  (mem_store),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  logic [31:0] mem [64];
  assign mem_rdata = mem_load ? mem[mem_addr[5:0]] : 32'hDEADBEEF;
  always @(posedge clk) if (mem_store) mem[mem_addr[5:0]] <= mem_wdata;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          t_acc;
    int          lat;
    string       name;
  } resp_t;

  resp_t       rq [$];
  logic [63:0] sq [$];
  logic [31:0] lq [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_load = 0;
  int n_store = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    resp_t       e;
    logic [63:0] s;
    if (mem_load && mem_store) begin
      errors++;
      $display("FAIL load_store_overlap actual=both required=exclusive");
    end
    if (mem_load) begin
      n_load++;
      if (lq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load actual=addr %h required=none", mem_addr);
      end else begin
        chk("load_addr", mem_addr, lq.pop_front());
      end
    end
    if (mem_store) begin
      n_store++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_store actual=addr %h required=none", mem_addr);
      end else begin
        s = sq.pop_front();
        chk("store_addr", mem_addr, s[63:32]);
        chk("store_wdata", mem_wdata, s[31:0]);
      end
    end
    if (resp_valid) begin
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp actual=valid required=idle");
      end else begin
        e = rq.pop_front();
        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
        chk({e.name, "_fault"}, {31'h0, resp_fault}, {31'h0, e.fault});
        chk({e.name, "_latency"}, cyc - e.t_acc + 1, e.lat);
      end
    end
  end

  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_f, input int lat,
                       input int nl, input int ns, input logic [31:0] swd);
    int    l0;
    int    s0;
    resp_t e;
    @(negedge clk);
    l0 = n_load;
    s0 = n_store;
    for (int i = 0; i < nl; i++) lq.push_back({26'h0, a[7:2]});
    for (int i = 0; i < ns; i++) sq.push_back({26'h0, a[7:2], swd});
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    e.rdata = exp_rd;
    e.fault = exp_f;
    e.t_acc = cyc;
    e.lat   = lat;
    e.name  = nm;
    rq.push_back(e);
    req_valid  = 1'b0;
    req_addr   = 32'hFFFFFFFF;
    req_wdata  = 32'hFFFFFFFF;
    req_funct3 = 3'b111;
    chk({nm, "_busy"}, {31'h0, req_ready}, 32'h0);
    for (int i = 0; i < 8 && !req_ready; i++) @(negedge clk);
    #1;
    chk({nm, "_done"}, {31'h0, req_ready}, 32'h1);
    chk({nm, "_nload"}, n_load - l0, nl);
    chk({nm, "_nstore"}, n_store - s0, ns);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_fault", {31'h0, resp_fault}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_en", {30'h0, mem_load, mem_store}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue("sw",  1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2, 0, 1, 32'h80FF7F01);
    issue("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 32'h0);
    issue("lb",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0);
    issue("lh",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h0);
    issue("lhu", 1'b0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2, 1, 0, 32'h0);
    issue("lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'h80FF7F01, 1'b0, 2, 1, 0, 32'h0);

    mem[4] = 32'h11223344;
    issue("sb",  1'b1, 3'b000, 32'h11, 32'h123456AA, 32'h0, 1'b0, 3, 1, 1, 32'h1122AA44);
    issue("sh",  1'b1, 3'b001, 32'h12, 32'h5555BEEF, 32'h0, 1'b0, 3, 1, 1, 32'hBEEFAA44);
    issue("lw_rmw", 1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEFAA44, 1'b0, 2, 1, 0, 32'h0);
    issue("ill_ld", 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    issue("lh_neg", 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAA44, 1'b0, 2, 1, 0, 32'h0);
    issue("ill_st", 1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    issue("ill_sbx", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);

    mem[0] = 32'hCAFEF00D;
`ifdef LSU_ALIGN_CHECK_EN
    issue("lw_mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    issue("sh_mis", 1'b1, 3'b001, 32'h01, 32'h00001234, 32'h0, 1'b1, 1, 0, 0, 32'h0);
    issue("lw_zero", 1'b0, 3'b010, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0, 32'h0);
`else
    issue("lw_mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'hBEEFAA44, 1'b0, 2, 1, 0, 32'h0);
    issue("sh_mis", 1'b1, 3'b001, 32'h01, 32'h00001234, 32'h0, 1'b0, 3, 1, 1, 32'hCAFE1234);
    issue("lw_zero", 1'b0, 3'b010, 32'h00, 32'h0, 32'hCAFE1234, 1'b0, 2, 1, 0, 32'h0);
`endif

    mem[8] = 32'h55667788;
    s0 = n_store;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h21;
    req_wdata  = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_in_rmw_rd", {31'h0, mem_load}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_mem_en", {30'h0, mem_load, mem_store}, 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    chk("abort_resp", {30'h0, resp_valid, resp_fault}, 32'h0);
    chk("abort_rdata", resp_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
    chk("abort_no_store", n_store - s0, 0);
    chk("abort_mem_word", mem[8], 32'h55667788);

    chk("left_resp", rq.size(), 0);
    chk("left_load", lq.size(), 0);
    chk("left_store", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
